// File: rtl/pkg_ascensor.sv
// ============================================================================
// Module : pkg_ascensor
// Shared types for the elevator car controller: state enum, floor width and
// one-hot floor decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_ascensor;

    localparam int PISO_W = 2;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUBIR  = 2'd1,
        BAJAR  = 2'd2,
        PUERTA = 2'd3
    } estado_t;

    typedef struct packed {
        logic              valido;
        logic [PISO_W-1:0] piso;
    } piso_dec_t;

    // Zero or multiple bits set decode as invalid.
    function automatic piso_dec_t onehot_a_piso(input logic [3:0] oh);
        piso_dec_t r;
        r.valido = 1'b0;
        r.piso   = '0;
        case (oh)
            4'b0001: begin r.valido = 1'b1; r.piso = 2'd0; end
            4'b0010: begin r.valido = 1'b1; r.piso = 2'd1; end
            4'b0100: begin r.valido = 1'b1; r.piso = 2'd2; end
            4'b1000: begin r.valido = 1'b1; r.piso = 2'd3; end
            default: begin r.valido = 1'b0; r.piso = '0;   end
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_intervalo.sv
// ============================================================================
// Module : contador_intervalo
// Loadable down-counter with zero flag and freeze input; saturates at zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_intervalo #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carga_i,
    input  logic [ANCHO-1:0] valor_i,
    input  logic             congela_i,
    output logic             cero_o
);

    logic [ANCHO-1:0] cuenta_q;
    logic [ANCHO-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i) begin
            cuenta_d = valor_i;
        end else if (!congela_i && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cero_o = (cuenta_q == '0);

endmodule

`default_nettype wire

// File: rtl/control_cabina.sv
// ============================================================================
// Module : control_cabina
// Elevator car controller: pops one-hot floor requests, drives the motor one
// floor per travel interval and opens the door on arrival.
// Optional emergency stop input enabled with macro PARO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_cabina
    import pkg_ascensor::*;
#(
    parameter int N_PISOS      = 4,
    parameter int TICKS_PISO   = 50_000_000,
    parameter int TICKS_PUERTA = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        memoria,
    input  logic              mem_valid,
    output logic              mem_ready,
    output logic [PISO_W-1:0] piso,
    output logic              motor_subir,
    output logic              motor_bajar,
    output logic              puerta,
    output logic              ocupado,
    output logic              err_instr
`ifdef PARO_EN
    ,
    input  logic              paro
`endif
);

    localparam int T_MAX = (TICKS_PISO > TICKS_PUERTA) ? TICKS_PISO : TICKS_PUERTA;
    localparam int CNT_W = $clog2(T_MAX);
    localparam logic [CNT_W-1:0]  CARGA_PISO   = CNT_W'(TICKS_PISO - 1);
    localparam logic [CNT_W-1:0]  CARGA_PUERTA = CNT_W'(TICKS_PUERTA - 1);
    localparam logic [PISO_W-1:0] PISO_MAX     = PISO_W'(N_PISOS - 1);

    estado_t           estado_q, estado_d;
    logic [PISO_W-1:0] piso_q, piso_d;
    logic [PISO_W-1:0] destino_q, destino_d;
    logic              err_q, err_d;

    logic              paro_w;
    logic              carga_w;
    logic [CNT_W-1:0]  valor_carga_w;
    logic              cero_w;
    piso_dec_t         dec_w;
    logic [PISO_W-1:0] piso_sig_w;

`ifdef PARO_EN
    assign paro_w = paro;
`else
    assign paro_w = 1'b0;
`endif

    // One counter serves both travel and door timing; they never overlap.
    contador_intervalo #(
        .ANCHO (CNT_W)
    ) u_contador (
        .clk       (clk),
        .rst_n     (rst_n),
        .carga_i   (carga_w),
        .valor_i   (valor_carga_w),
        .congela_i (paro_w),
        .cero_o    (cero_w)
    );

    always_comb begin
        estado_d      = estado_q;
        piso_d        = piso_q;
        destino_d     = destino_q;
        err_d         = 1'b0;
        carga_w       = 1'b0;
        valor_carga_w = CARGA_PISO;
        dec_w         = onehot_a_piso(memoria);
        piso_sig_w    = piso_q;

        if (!paro_w) begin
            case (estado_q)
                REPOSO: begin
                    if (mem_valid) begin
                        if (dec_w.valido) begin
                            destino_d = dec_w.piso;
                            carga_w   = 1'b1;
                            if (dec_w.piso == piso_q) begin
                                estado_d      = PUERTA;
                                valor_carga_w = CARGA_PUERTA;
                            end else if (dec_w.piso > piso_q) begin
                                estado_d = SUBIR;
                            end else begin
                                estado_d = BAJAR;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SUBIR, BAJAR: begin
                    if (cero_w) begin
                        if (estado_q == SUBIR) begin
                            piso_sig_w = (piso_q == PISO_MAX) ? piso_q : piso_q + 1'b1;
                        end else begin
                            piso_sig_w = (piso_q == '0) ? piso_q : piso_q - 1'b1;
                        end
                        piso_d  = piso_sig_w;
                        carga_w = 1'b1;
                        if (piso_sig_w == destino_q) begin
                            estado_d      = PUERTA;
                            valor_carga_w = CARGA_PUERTA;
                        end
                    end
                end
                PUERTA: begin
                    if (cero_w) begin
                        estado_d = REPOSO;
                    end
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            piso_q    <= '0;
            destino_q <= '0;
            err_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            piso_q    <= piso_d;
            destino_q <= destino_d;
            err_q     <= err_d;
        end
    end

    assign mem_ready   = (estado_q == REPOSO) && !paro_w;
    assign motor_subir = (estado_q == SUBIR)  && !paro_w;
    assign motor_bajar = (estado_q == BAJAR)  && !paro_w;
    assign puerta      = (estado_q == PUERTA);
    assign ocupado     = (estado_q != REPOSO);
    assign piso        = piso_q;
    assign err_instr   = err_q;

endmodule

`default_nettype wire
